// File: rtl/product_accumulator.sv
// Product accumulator: sums unsigned multiplier products into one saturating
// result per vector, with valid/ready handshakes on both the input and output sides.
module product_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W = 24,
    parameter int MAX_LEN = 256,
    localparam int CNT_W = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] prod_i,
    input  logic              prod_last,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc_o,
    output logic [CNT_W-1:0]  len_o,
    output logic              ovf_o,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             ovf;

    logic             accept;
    logic             close;
    logic [ACC_W:0]   sum;
    logic [CNT_W-1:0] count_next;

    assign accept     = prod_valid && prod_ready;
    // One spare bit catches the carry out; a set top bit means saturate.
    assign sum        = (ACC_W + 1)'(acc) + (ACC_W + 1)'(prod_i);
    assign count_next = (state == IDLE) ? CNT_W'(1) : count + CNT_W'(1);
    assign close      = accept && (prod_last || (count_next == MAX_CNT));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = close ? DONE : ACCUM;
            ACCUM:   if (close) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        prod_ready = (state != DONE);
        out_valid  = (state == DONE);
        acc_o      = out_valid ? acc   : '0;
        len_o      = out_valid ? count : '0;
        ovf_o      = out_valid ? ovf   : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            count <= count_next;
            if (state == IDLE) begin
                acc <= ACC_W'(prod_i);
                ovf <= 1'b0;
            end else if (sum[ACC_W]) begin
                acc <= '1;
                ovf <= 1'b1;
            end else begin
                acc <= sum[ACC_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: one default instance plus narrow-accumulator
// and short-vector variants, all driven from shared stimulus.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] prod;
    logic        last;
    logic        valid;
    logic        out_ready;

    logic        pr0, ov0, ovf0;
    logic [23:0] acc0;
    logic [8:0]  len0;

    logic        pr1, ov1, ovf1;
    logic [17:0] acc1;
    logic [8:0]  len1;

    logic        pr2, ov2, ovf2;
    logic [23:0] acc2;
    logic [2:0]  len2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    product_accumulator u_dut (
        .clk(clk), .rst(rst), .prod_i(prod), .prod_last(last), .prod_valid(valid),
        .prod_ready(pr0), .acc_o(acc0), .len_o(len0), .ovf_o(ovf0),
        .out_valid(ov0), .out_ready(out_ready)
    );

    product_accumulator #(.ACC_W(18)) u_sat (
        .clk(clk), .rst(rst), .prod_i(prod), .prod_last(last), .prod_valid(valid),
        .prod_ready(pr1), .acc_o(acc1), .len_o(len1), .ovf_o(ovf1),
        .out_valid(ov1), .out_ready(out_ready)
    );

    product_accumulator #(.MAX_LEN(4)) u_fc (
        .clk(clk), .rst(rst), .prod_i(prod), .prod_last(last), .prod_valid(valid),
        .prod_ready(pr2), .acc_o(acc2), .len_o(len2), .ovf_o(ovf2),
        .out_valid(ov2), .out_ready(out_ready)
    );

    // Inputs change and outputs are sampled only on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = 1'b0; last = 1'b0; prod = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b1; prod = 16'd123; last = 1'b1; out_ready = 1'b0;
        step();
        step();
        total++; if (acc0 !== 24'd0) begin bad++; $display("FAIL reset_acc: got %0d want 0", acc0); end
        total++; if (len0 !== 9'd0) begin bad++; $display("FAIL reset_len: got %0d want 0", len0); end
        total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf0); end
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", ov0); end
        rst = 1'b0; valid = 1'b0; last = 1'b0;
        total++; if (pr0 !== 1'b1) begin bad++; $display("FAIL reset_prod_ready: got %b want 1", pr0); end
    endtask

    task automatic test_basic();
        do_reset();
        out_ready = 1'b1;
        // prod_last without prod_valid must not close anything.
        valid = 1'b0; last = 1'b1; prod = 16'd999;
        step();
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL basic_idle_last: out_valid got %b want 0", ov0); end
        valid = 1'b1; last = 1'b0; prod = 16'd65025;
        step();
        prod = 16'd2;
        step();
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got %b want 0", ov0); end
        prod = 16'd100; last = 1'b1;
        step();
        valid = 1'b0; last = 1'b0;
        total++; if (ov0 !== 1'b1) begin bad++; $display("FAIL basic_out_valid: got %b want 1", ov0); end
        total++; if (acc0 !== 24'd65127) begin bad++; $display("FAIL basic_acc: got %0d want 65127", acc0); end
        total++; if (len0 !== 9'd3) begin bad++; $display("FAIL basic_len: got %0d want 3", len0); end
        total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL basic_ovf: got %b want 0", ovf0); end
        total++; if (pr0 !== 1'b0) begin bad++; $display("FAIL basic_ready_done: got %b want 0", pr0); end
        step();
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL basic_idle_valid: got %b want 0", ov0); end
        total++; if (acc0 !== 24'd0) begin bad++; $display("FAIL basic_idle_acc: got %0d want 0", acc0); end
        total++; if (pr0 !== 1'b1) begin bad++; $display("FAIL basic_idle_ready: got %b want 1", pr0); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        valid = 1'b1; prod = 16'd7; last = 1'b1;
        step();
        prod = 16'd9;
        for (int i = 0; i < 5; i++) begin
            total++; if (ov0 !== 1'b1 || acc0 !== 24'd7 || len0 !== 9'd1)
                begin bad++; $display("FAIL bp_hold[%0d]: got v=%b acc=%0d len=%0d want v=1 acc=7 len=1", i, ov0, acc0, len0); end
            total++; if (pr0 !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d]: got %b want 0", i, pr0); end
            step();
        end
        out_ready = 1'b1;
        total++; if (acc0 !== 24'd7) begin bad++; $display("FAIL bp_handoff_acc: got %0d want 7", acc0); end
        step();
        total++; if (ov0 !== 1'b0 || pr0 !== 1'b1)
            begin bad++; $display("FAIL bp_bubble: got v=%b r=%b want v=0 r=1", ov0, pr0); end
        step();
        valid = 1'b0; last = 1'b0;
        total++; if (ov0 !== 1'b1 || acc0 !== 24'd9 || len0 !== 9'd1)
            begin bad++; $display("FAIL bp_next_vector: got v=%b acc=%0d len=%0d want v=1 acc=9 len=1", ov0, acc0, len0); end
        step();
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b1;
        valid = 1'b1; prod = 16'd65025; last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            last = (i == 4);
            step();
        end
        valid = 1'b0; last = 1'b0;
        total++; if (acc1 !== 18'd262143) begin bad++; $display("FAIL sat_acc: got %0d want 262143", acc1); end
        total++; if (ovf1 !== 1'b1) begin bad++; $display("FAIL sat_ovf: got %b want 1", ovf1); end
        total++; if (len1 !== 9'd5) begin bad++; $display("FAIL sat_len: got %0d want 5", len1); end
        total++; if (acc0 !== 24'd325125 || ovf0 !== 1'b0)
            begin bad++; $display("FAIL wide_no_sat: got acc=%0d ovf=%b want acc=325125 ovf=0", acc0, ovf0); end
        step();
        valid = 1'b1; prod = 16'd1; last = 1'b1;
        step();
        valid = 1'b0; last = 1'b0;
        total++; if (ov1 !== 1'b1 || acc1 !== 18'd1 || ovf1 !== 1'b0)
            begin bad++; $display("FAIL sat_clear: got v=%b acc=%0d ovf=%b want v=1 acc=1 ovf=0", ov1, acc1, ovf1); end
        step();
    endtask

    task automatic test_force_close();
        do_reset();
        out_ready = 1'b1;
        valid = 1'b1; prod = 16'd10; last = 1'b0;
        for (int i = 0; i < 4; i++) step();
        prod = 16'd3; last = 1'b1;
        total++; if (ov2 !== 1'b1 || acc2 !== 24'd40 || len2 !== 3'd4)
            begin bad++; $display("FAIL fc_close: got v=%b acc=%0d len=%0d want v=1 acc=40 len=4", ov2, acc2, len2); end
        step();
        total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL fc_bubble: got %b want 0", ov2); end
        step();
        valid = 1'b0; last = 1'b0;
        total++; if (ov2 !== 1'b1 || acc2 !== 24'd3 || len2 !== 3'd1)
            begin bad++; $display("FAIL fc_next: got v=%b acc=%0d len=%0d want v=1 acc=3 len=1", ov2, acc2, len2); end
        step();
    endtask

    task automatic test_reset_mid_vector();
        do_reset();
        out_ready = 1'b1;
        valid = 1'b1; last = 1'b0; prod = 16'd500;
        step();
        prod = 16'd600;
        step();
        rst = 1'b1; valid = 1'b0;
        step();
        rst = 1'b0;
        total++; if (ov0 !== 1'b0 || acc0 !== 24'd0 || pr0 !== 1'b1)
            begin bad++; $display("FAIL mid_reset: got v=%b acc=%0d r=%b want v=0 acc=0 r=1", ov0, acc0, pr0); end
        step();
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL mid_reset_quiet: got %b want 0", ov0); end
        valid = 1'b1; prod = 16'd5; last = 1'b1;
        step();
        valid = 1'b0; last = 1'b0;
        total++; if (ov0 !== 1'b1 || acc0 !== 24'd5 || len0 !== 9'd1)
            begin bad++; $display("FAIL mid_reset_result: got v=%b acc=%0d len=%0d want v=1 acc=5 len=1", ov0, acc0, len0); end
        step();
    endtask

    initial begin
        rst = 1'b1; prod = '0; last = 1'b0; valid = 1'b0; out_ready = 1'b0;
        step();
        test_reset();
        test_basic();
        test_back_to_back();
        test_saturation();
        test_force_close();
        test_reset_mid_vector();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
